// File: rtl/sha256_seq_pkg.sv
// Shared definitions for the SHA-256 round sequencer: FSM state encoding,
// default geometry of a SHA-256 block schedule and a counter-width helper.
package sha256_seq_pkg;

  localparam int DEF_MAX_BLOCKS   = 4;
  localparam int DEF_ROUNDS       = 64;
  localparam int DEF_MSG_WORDS    = 16;
  localparam int DEF_DIGEST_WORDS = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_ACCUM = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } seq_state_t;

  // Width of a counter that must hold values 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sha_round_sequencer_if.sv
// Control/address bundle between the round sequencer and the hash datapath.
// The sequencer sits on the slave side; the datapath/driver on the master side.
interface sha_round_sequencer_if
  import sha256_seq_pkg::*;
#(
  parameter int MAX_BLOCKS   = DEF_MAX_BLOCKS,
  parameter int ROUNDS       = DEF_ROUNDS,
  parameter int MSG_WORDS    = DEF_MSG_WORDS,
  parameter int DIGEST_WORDS = DEF_DIGEST_WORDS
) ();

  logic                                   step;
  logic                                   start;
  logic [$clog2(MAX_BLOCKS+1)-1:0]        n_blocks;
  logic                                   ready;
  logic [$clog2(MAX_BLOCKS*MSG_WORDS)-1:0] in_mem_addr;
  logic                                   w_load;
  logic [$clog2(ROUNDS)-1:0]              k_num;
  logic                                   round_en;
  logic                                   accum_en;
  logic [$clog2(DIGEST_WORDS)-1:0]        out_mem_addr;
  logic                                   en_mem_out;
  logic                                   done;

  modport slave (
    input  step, start, n_blocks,
    output ready, in_mem_addr, w_load, k_num, round_en, accum_en,
           out_mem_addr, en_mem_out, done
  );

  modport master (
    output step, start, n_blocks,
    input  ready, in_mem_addr, w_load, k_num, round_en, accum_en,
           out_mem_addr, en_mem_out, done
  );

endinterface

// File: rtl/sha_round_sequencer_seq_counter.sv
// Wrapping up-counter used for the word, round, block and output-index
// counters: counts on enable, returns to zero after its terminal value,
// and a synchronous clear takes priority over counting.
module seq_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] terminal,
  output logic [WIDTH-1:0] count,
  output logic             at_term
);

  assign at_term = (count == terminal);

  // Count register: clear wins, otherwise advance and wrap at the terminal value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= at_term ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/sha_round_sequencer.sv
// SHA-256 round sequencer: walks LOAD -> ROUND -> ACCUM for each message
// block, then WRITE for the digest and a single-cycle DONE. Every advance is
// qualified by step. Optional feature macro: ROUND_SEQ_ABORT_EN adds an abort
// input that drops any running job back to IDLE without signalling done.
module sha_round_sequencer
  import sha256_seq_pkg::*;
#(
  parameter int MAX_BLOCKS   = DEF_MAX_BLOCKS,
  parameter int ROUNDS       = DEF_ROUNDS,
  parameter int MSG_WORDS    = DEF_MSG_WORDS,
  parameter int DIGEST_WORDS = DEF_DIGEST_WORDS
) (
  input  logic                  clk,
  input  logic                  reset_n,
`ifdef ROUND_SEQ_ABORT_EN
  input  logic                  abort,
`endif
  sha_round_sequencer_if.slave  bus
);

  localparam int BLK_W  = $clog2(MAX_BLOCKS+1);
  localparam int IN_W   = $clog2(MAX_BLOCKS*MSG_WORDS);
  localparam int K_W    = $clog2(ROUNDS);
  localparam int OUT_W  = $clog2(DIGEST_WORDS);
  localparam int WORD_W = cnt_width(MSG_WORDS);
  localparam int RND_W  = cnt_width(ROUNDS);
  localparam int OIDX_W = cnt_width(DIGEST_WORDS);

  seq_state_t        state, state_nxt;
  logic [BLK_W-1:0]  n_lat;
  logic              accept, kill, clr_cnt;
  logic              w_load, round_en, accum_en, en_mem_out, done;

  logic [WORD_W-1:0] word_cnt;
  logic [RND_W-1:0]  round_cnt;
  logic [BLK_W-1:0]  blk_cnt;
  logic [OIDX_W-1:0] oidx_cnt;
  logic              word_term, round_term, blk_term, oidx_term;

  assign accept = (state == ST_IDLE) && bus.start &&
                  (bus.n_blocks != '0) && (bus.n_blocks <= BLK_W'(MAX_BLOCKS));

`ifdef ROUND_SEQ_ABORT_EN
  assign kill = abort && (state != ST_IDLE);
`else
  assign kill = 1'b0;
`endif

  assign clr_cnt = accept | kill;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Block count is captured only when a job is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_lat <= '0;
    end else if (accept) begin
      n_lat <= bus.n_blocks;
    end
  end

  // Next-state and strobe decode; every strobe is the state decode gated by step.
  always_comb begin
    state_nxt  = state;
    w_load     = 1'b0;
    round_en   = 1'b0;
    accum_en   = 1'b0;
    en_mem_out = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_load = bus.step;
        if (bus.step && word_term) state_nxt = ST_ROUND;
      end
      ST_ROUND: begin
        round_en = bus.step;
        if (bus.step && round_term) state_nxt = ST_ACCUM;
      end
      ST_ACCUM: begin
        accum_en = bus.step;
        if (bus.step) state_nxt = blk_term ? ST_WRITE : ST_LOAD;
      end
      ST_WRITE: begin
        en_mem_out = bus.step;
        if (bus.step && oidx_term) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (kill) begin
      w_load     = 1'b0;
      round_en   = 1'b0;
      accum_en   = 1'b0;
      en_mem_out = 1'b0;
      done       = 1'b0;
      state_nxt  = ST_IDLE;
    end
  end

  seq_counter #(.WIDTH(WORD_W)) u_word (
    .clk(clk), .reset_n(reset_n), .en(w_load), .clr(clr_cnt),
    .terminal(WORD_W'(MSG_WORDS-1)), .count(word_cnt), .at_term(word_term)
  );

  seq_counter #(.WIDTH(RND_W)) u_round (
    .clk(clk), .reset_n(reset_n), .en(round_en), .clr(clr_cnt),
    .terminal(RND_W'(ROUNDS-1)), .count(round_cnt), .at_term(round_term)
  );

  seq_counter #(.WIDTH(BLK_W)) u_blk (
    .clk(clk), .reset_n(reset_n), .en(accum_en), .clr(clr_cnt),
    .terminal(n_lat - BLK_W'(1)), .count(blk_cnt), .at_term(blk_term)
  );

  seq_counter #(.WIDTH(OIDX_W)) u_oidx (
    .clk(clk), .reset_n(reset_n), .en(en_mem_out), .clr(clr_cnt),
    .terminal(OIDX_W'(DIGEST_WORDS-1)), .count(oidx_cnt), .at_term(oidx_term)
  );

  assign bus.ready        = (state == ST_IDLE);
  assign bus.in_mem_addr  = IN_W'(blk_cnt) * IN_W'(MSG_WORDS) + IN_W'(word_cnt);
  assign bus.k_num        = K_W'(round_cnt);
  assign bus.out_mem_addr = OUT_W'(oidx_cnt);
  assign bus.w_load       = w_load;
  assign bus.round_en     = round_en;
  assign bus.accum_en     = accum_en;
  assign bus.en_mem_out   = en_mem_out;
  assign bus.done         = done;

endmodule

// File: tb/tb_sha_round_sequencer.sv
// Scoreboard bench for sha_round_sequencer: stimulus pushes the expected
// strobe/address sequence and done time for each job; a monitor on the
// falling edge pops and compares whenever the sequencer presents an output.
module tb_sha_round_sequencer;

  localparam int MAX_BLOCKS   = 4;
  localparam int ROUNDS       = 64;
  localparam int MSG_WORDS    = 16;
  localparam int DIGEST_WORDS = 8;
  localparam int JOB_STEPS_PER_BLOCK = MSG_WORDS + ROUNDS + 1;

  typedef struct {
    int kind;
    int value;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   cycle_count = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t strobe_q[$];
  int   done_q[$];

`ifdef ROUND_SEQ_ABORT_EN
  logic abort;
`endif

  sha_round_sequencer_if #(
    .MAX_BLOCKS(MAX_BLOCKS), .ROUNDS(ROUNDS),
    .MSG_WORDS(MSG_WORDS), .DIGEST_WORDS(DIGEST_WORDS)
  ) bus ();

  sha_round_sequencer #(
    .MAX_BLOCKS(MAX_BLOCKS), .ROUNDS(ROUNDS),
    .MSG_WORDS(MSG_WORDS), .DIGEST_WORDS(DIGEST_WORDS)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
`ifdef ROUND_SEQ_ABORT_EN
    .abort(abort),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_count <= cycle_count + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle_count);
    end
  endtask

  // Reference model: the strobe sequence a whole job must produce.
  task automatic pushJobModel(input int n);
    for (int b = 0; b < n; b++) begin
      for (int w = 0; w < MSG_WORDS; w++) strobe_q.push_back('{1, b*MSG_WORDS + w});
      for (int r = 0; r < ROUNDS; r++) strobe_q.push_back('{2, r});
      strobe_q.push_back('{3, 0});
    end
    for (int o = 0; o < DIGEST_WORDS; o++) strobe_q.push_back('{4, o});
  endtask

  task automatic startJob(input int n, output int accept_cycle);
    checkOutput("ready_before_start", int'(bus.ready), 1);
    bus.start    = 1'b1;
    bus.n_blocks = 3'(n);
    bus.step     = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    bus.start    = 1'b0;
    accept_cycle = cycle_count;
    pushJobModel(n);
  endtask

  task automatic waitDone();
    for (int i = 0; i < 4 && done_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("done_seen_in_time", done_q.size(), 0);
    done_q.delete();
    checkOutput("strobe_queue_drained", strobe_q.size(), 0);
    strobe_q.delete();
    @(posedge clk); #1;
  endtask

  // mode 0: step always 1; mode 1: step toggles 1/0; mode 2: random step.
  // poke_at >= 0 raises start (with a different block count) mid-job.
  task automatic applyStimulus(input int n, input int mode, input int poke_at);
    int acc, total, steps, i;
    bit s;
    total = n * JOB_STEPS_PER_BLOCK + DIGEST_WORDS;
    startJob(n, acc);
    steps = 0;
    i = 0;
    while (steps < total) begin
      case (mode)
        0:       s = 1'b1;
        1:       s = (i % 2 == 0);
        default: s = ($urandom_range(0, 3) != 0);
      endcase
      bus.step     = s;
      bus.start    = (poke_at >= 0 && steps == poke_at);
      bus.n_blocks = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
      bus.start = 1'b0;
      i++;
      if (s) steps++;
    end
    case (mode)
      0:       done_q.push_back(acc + total);
      1:       done_q.push_back(acc + 2*total - 1);
      default: done_q.push_back(cycle_count);
    endcase
    bus.step = 1'($urandom_range(0, 1));
    waitDone();
  endtask

  task automatic badStart(input int n);
    checkOutput("ready_before_bad_start", int'(bus.ready), 1);
    bus.start    = 1'b1;
    bus.n_blocks = 3'(n);
    bus.step     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checkOutput("bad_start_ready", int'(bus.ready), 1);
    repeat (4) begin
      @(posedge clk); #1;
    end
    checkOutput("bad_start_still_ready", int'(bus.ready), 1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ready"},        int'(bus.ready), 1);
    checkOutput({tag, "_in_mem_addr"},  int'(bus.in_mem_addr), 0);
    checkOutput({tag, "_k_num"},        int'(bus.k_num), 0);
    checkOutput({tag, "_out_mem_addr"}, int'(bus.out_mem_addr), 0);
    checkOutput({tag, "_strobes"},
                int'(bus.w_load) + int'(bus.round_en) + int'(bus.accum_en) + int'(bus.en_mem_out), 0);
    checkOutput({tag, "_done"},         int'(bus.done), 0);
  endtask

  task automatic resetMidJob();
    int acc, steps;
    startJob(2, acc);
    steps = 0;
    bus.step = 1'b1;
    while (steps < MSG_WORDS + 30) begin
      @(posedge clk); #1;
      steps++;
    end
    checkOutput("k_num_before_reset", int'(bus.k_num), 30);
    reset_n = 1'b0;
    #1;
    checkAllZero("mid_reset");
    strobe_q.delete();
    done_q.delete();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
    end
    checkOutput("after_reset_idle", int'(bus.ready), 1);
  endtask

`ifdef ROUND_SEQ_ABORT_EN
  task automatic abortDuringWrite();
    int acc, steps;
    startJob(1, acc);
    steps = 0;
    bus.step = 1'b1;
    while (steps < JOB_STEPS_PER_BLOCK + 3) begin
      @(posedge clk); #1;
      steps++;
    end
    checkOutput("abort_point_oidx", int'(bus.out_mem_addr), 3);
    abort = 1'b1;
    #1;
    checkOutput("abort_gates_write", int'(bus.en_mem_out), 0);
    strobe_q.delete();
    @(posedge clk); #1;
    abort = 1'b0;
    checkOutput("abort_idle", int'(bus.ready), 1);
    checkOutput("abort_oidx_cleared", int'(bus.out_mem_addr), 0);
    repeat (4) begin
      @(posedge clk); #1;
    end
  endtask
`endif

  // Monitor: compare every presented strobe and done against the scoreboard.
  initial begin
    int   n_str, act_kind, act_val;
    exp_t e;
    bit   expect_ready;
    expect_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        n_str = int'(bus.w_load) + int'(bus.round_en) + int'(bus.accum_en) + int'(bus.en_mem_out);
        act_kind = 0;
        act_val  = 0;
        if (bus.w_load)     begin act_kind = 1; act_val = int'(bus.in_mem_addr);  end
        if (bus.round_en)   begin act_kind = 2; act_val = int'(bus.k_num);        end
        if (bus.accum_en)   begin act_kind = 3; act_val = 0;                      end
        if (bus.en_mem_out) begin act_kind = 4; act_val = int'(bus.out_mem_addr); end
        if (n_str > 0) begin
          checkOutput("strobe_needs_step", int'(bus.step), 1);
          checkOutput("single_strobe", n_str, 1);
          if (strobe_q.size() == 0) begin
            checkOutput("unexpected_strobe", act_kind, 0);
          end else begin
            e = strobe_q.pop_front();
            checkOutput("strobe_kind", act_kind, e.kind);
            if (e.kind != 3) checkOutput("strobe_addr", act_val, e.value);
          end
        end
        if (bus.done) begin
          if (done_q.size() == 0) begin
            checkOutput("unexpected_done", int'(bus.done), 0);
          end else begin
            checkOutput("done_cycle", cycle_count, done_q.pop_front());
            checkOutput("ready_during_done", int'(bus.ready), 0);
            expect_ready = 1'b1;
          end
        end else if (expect_ready) begin
          checkOutput("ready_after_done", int'(bus.ready), 1);
          expect_ready = 1'b0;
        end
      end else begin
        expect_ready = 1'b0;
      end
    end
  end

  // Main sequence: reset, directed jobs, illegal starts, mid-job reset, random jobs.
  initial begin
    reset_n      = 1'b1;
    bus.step     = 1'b0;
    bus.start    = 1'b0;
    bus.n_blocks = '0;
`ifdef ROUND_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    #2 reset_n = 1'b0;
    #1;
    checkAllZero("reset");
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    checkAllZero("post_reset");

    $display("[TB] single block, step held high");
    applyStimulus(1, 0, -1);
    $display("[TB] three blocks, step held high");
    applyStimulus(3, 0, -1);
    $display("[TB] single block, step toggling");
    applyStimulus(1, 1, -1);
    $display("[TB] illegal block counts");
    badStart(0);
    badStart(MAX_BLOCKS + 1);
    $display("[TB] start raised during ROUND");
    applyStimulus(2, 0, MSG_WORDS + 10);
    $display("[TB] reset in the middle of a job");
    resetMidJob();
    applyStimulus(1, 0, -1);
    $display("[TB] random jobs with random step");
    repeat (6) applyStimulus(int'($urandom_range(1, MAX_BLOCKS)), 2, -1);
    applyStimulus(MAX_BLOCKS, 2, -1);
`ifdef ROUND_SEQ_ABORT_EN
    $display("[TB] abort during WRITE");
    abortDuringWrite();
    applyStimulus(1, 0, -1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha_round_sequencer.md
SHA_ROUND_SEQUENCER -- requirements
Module: sha_round_sequencer

Interface
REQ-001 Parameter MAX_BLOCKS, default 4: maximum 512-bit message blocks per hash, range 1..255.
REQ-002 Parameter ROUNDS, default 64: compression rounds per block.
REQ-003 Parameter MSG_WORDS, default 16: 32-bit words loaded per block.
REQ-004 Parameter DIGEST_WORDS, default 8: words written to output memory.
REQ-005 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-006 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 Port step, input, 1: advance enable; sequencer advances only in cycles with step=1.
REQ-008 Port start, input, 1: request to hash n_blocks blocks.
REQ-009 Port n_blocks, input, $clog2(MAX_BLOCKS+1): block count for this job.
REQ-010 Port ready, output, 1: high in IDLE only.
REQ-011 Port in_mem_addr, output, $clog2(MAX_BLOCKS*MSG_WORDS): input memory word address.
REQ-012 Port w_load, output, 1: load message word this cycle.
REQ-013 Port k_num, output, $clog2(ROUNDS): current round constant index.
REQ-014 Port round_en, output, 1: perform one compression round this cycle.
REQ-015 Port accum_en, output, 1: add working variables into hash state this cycle.
REQ-016 Port out_mem_addr, output, $clog2(DIGEST_WORDS): output memory word address.
REQ-017 Port en_mem_out, output, 1: output memory write enable.
REQ-018 Port done, output, 1: one-cycle completion pulse.

Function
REQ-019 The block SHALL be a Moore FSM with states IDLE, LOAD, ROUND, ACCUM, WRITE, DONE; counters blk, word, round, oidx.
REQ-020 IDLE: start=1 with 1<=n_blocks<=MAX_BLOCKS SHALL latch n_blocks, clear all counters, enter LOAD (step not required); otherwise the FSM SHALL remain in IDLE.
REQ-021 LOAD: in_mem_addr=blk*MSG_WORDS+word; word increments per step; the step at word=MSG_WORDS-1 SHALL enter ROUND with round=0.
REQ-022 ROUND: k_num=round; the step at round=ROUNDS-1 SHALL enter ACCUM.
REQ-023 ACCUM SHALL last one step; then LOAD with blk+1 if blk<n_blocks-1, else WRITE with oidx=0.
REQ-024 WRITE: out_mem_addr=oidx; the step at oidx=DIGEST_WORDS-1 SHALL enter DONE.
REQ-025 DONE SHALL assert done for exactly one clk and return to IDLE irrespective of step.
REQ-026 Strobes w_load, round_en, accum_en, en_mem_out SHALL equal (state decode AND step); address outputs and k_num SHALL hold while step=0.
REQ-027 With step held at 1, start-accept to done SHALL be n_blocks*(MSG_WORDS+ROUNDS+1)+DIGEST_WORDS cycles (n=1, defaults: 89); ready returns the following cycle.
REQ-028 start outside IDLE SHALL be ignored; n_blocks SHALL be sampled only on acceptance.
REQ-029 All counters SHALL wrap to 0 on state exit; no counter exceeds its terminal value.

Reset
REQ-030 reset_n=0 SHALL force IDLE and zero all counters, addresses, k_num, strobes and done asynchronously; ready=1 during and after reset.
REQ-031 Reset mid-job SHALL abandon the job with no en_mem_out or done asserted afterwards.

Configuration
REQ-032 With ROUND_SEQ_ABORT_EN defined, input port abort (1 bit) SHALL exist; abort=1 in any non-IDLE state SHALL gate all strobes that cycle and enter IDLE next edge, clearing counters, with no done.
REQ-033 Without ROUND_SEQ_ABORT_EN, the abort port SHALL not exist and jobs run to completion.

Structure
REQ-034 Package sha256_seq_pkg SHALL hold the state enumeration and default ROUNDS, MSG_WORDS, DIGEST_WORDS constants.
REQ-035 Sub-module seq_counter (enable, clear, terminal value, terminal flag) SHALL implement word, round, blk and oidx counters.

Verification
REQ-036 Reset, n_blocks=1, start pulse, step=1 -> in_mem_addr 0..15, k_num 0..63, one accum_en, out_mem_addr 0..7 with en_mem_out, done 89 cycles after accept.
REQ-037 n_blocks=3 -> in_mem_addr 0..47 contiguous, three accum_en pulses, one WRITE sequence, done at 3*81+8=251 cycles.
REQ-038 step toggled 1/0 each cycle, n_blocks=1 -> identical address sequence, strobes only when step=1, done at cycle 177.
REQ-039 start with n_blocks=0 and n_blocks=MAX_BLOCKS+1 -> ready stays 1, no strobes; start during ROUND -> ignored, job unaffected.
REQ-040 reset_n low at k_num=30 -> all outputs 0 immediately, ready=1, no done; new job afterwards completes normally.
REQ-041 (ROUND_SEQ_ABORT_EN) abort during WRITE at oidx=3 -> en_mem_out 0 that cycle, IDLE next cycle, no done.
